smol_fetch_unit: RTL
====================

// Module: smol_fetch_unit
// PURPOSE
//  PC register and instruction-fetch stage fed by smolNextPC. Holds the current PC and fetches one
//  32-bit word per PC from instruction memory over a req/gnt/rvalid bus. Presents instr+pc to decode
//  with a valid/ready handshake. Loads the next PC on pc_load and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded at reset; the first fetch uses this address
//  XLEN       32             PC/address/instruction width; only 32 is supported
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  next_pc        in   32    PC from smolNextPC, sampled when pc_load=1
//  pc_load        in   1     core retired current instr; load next_pc, start new fetch
//  imem_req       out  1     fetch request valid
//  imem_addr      out  32    fetch byte address, word aligned
//  imem_gnt       in   1     request accepted this cycle
//  imem_rvalid    in   1     read data valid, one per granted request
//  imem_rdata     in   32    read data
//  instr_valid    out  1     instr/pc valid to decode
//  instr_ready    in   1     decode accepts instr
//  instr          out  32    fetched instruction
//  pc             out  32    PC of instr (the current PC register)
//  fetch_fault    out  1     next_pc misaligned (bits[1:0]!=0), held until next pc_load
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=REQ on first edge after release, imem_req=0 while in
//   reset, instr_valid=0, instr=32'h0000_0013 (NOP), fetch_fault=0, kill=0.
//  States: REQ, WAIT, HOLD, FAULT.
//   REQ:   imem_req=1, imem_addr=pc; addr stable and req held high until imem_gnt. gnt -> WAIT.
//   WAIT:  await imem_rvalid. rvalid & !kill -> latch imem_rdata into instr, -> HOLD.
//          rvalid & kill -> drop data, clear kill, -> REQ (with pc already updated).
//   HOLD:  instr_valid=1, instr/pc stable until instr_ready. instr_ready alone -> clears instr_valid,
//          stays HOLD (idle, valid=0) until pc_load.
//   FAULT: imem_req=0, instr_valid=0, fetch_fault=1.
//  pc_load (any state): pc<=next_pc next edge. If next_pc[1:0]!=0 -> FAULT (no request issued),
//   unless a transaction is outstanding (see below). Otherwise:
//   HOLD/FAULT -> REQ at next_pc; instr_valid drops the same edge.
//   REQ with gnt=0 -> stay REQ, address switches to next_pc (req not yet accepted).
//   REQ with gnt=1, or WAIT with rvalid=0 -> set kill; go/stay WAIT; response is discarded.
//   WAIT with rvalid=1 same cycle -> response discarded, -> REQ at next_pc.
//   Misaligned pc_load while a transaction is outstanding: kill set; FAULT entered once response drops.
//  Bus rules: at most one outstanding request; imem_rvalid earliest one cycle after gnt; rvalid with
//   no outstanding request is ignored.
//  Latency: zero-wait memory (gnt in REQ cycle, rvalid next cycle) -> instr_valid 2 cycles after
//   entering REQ. pc_load to next instr_valid = 3 cycles minimum.
//  Back-to-back pc_load: each pc_load overrides pending pc; only the last loaded pc is ever presented.
//  pc output always equals the PC register; instr_valid=1 guarantees instr belongs to pc.
//  Width: pc and imem_addr are 32-bit, no arithmetic in this block (pc+4 comes from smolNextPC).
// STRUCTURE
//  smol_pkg: fetch_state_t enum {REQ,WAIT,HOLD,FAULT}, INSTR_NOP=32'h0000_0013, XLEN.
//  Single module, no sub-module: PC register, kill flag, instr register and FSM are one always_ff
//   plus one always_comb next-state/output block.
// TESTING
//  1 Reset release, zero-wait memory returning 32'h00A00093 @0 -> imem_req@0, instr_valid 2 cycles later,
//    pc=0, instr=32'h00A00093; fetch_fault=0.
//  2 instr_ready=1 + pc_load, next_pc=0x4, memory stalls gnt 3 cycles -> imem_addr=0x4 held stable,
//    req high all 4 cycles, single transaction observed.
//  3 pc_load next_pc=0x100 while in WAIT for 0x8 (rvalid 2 cycles later) -> data for 0x8 dropped,
//    new req at 0x100, instr_valid only with pc=0x100.
//  4 pc_load next_pc=0x102 from HOLD -> fetch_fault=1, imem_req=0, instr_valid=0; then pc_load 0x200
//    -> fault clears, fetch at 0x200.
//  5 Assert rst_n=0 mid-WAIT with rvalid pending -> outputs reset immediately; late rvalid after
//    release ignored, first fetch at RESET_PC.
//  6 Random gnt/rvalid delays 0-5 cycles, random pc_load, 10k cycles -> scoreboard: every instr_valid
//    pairs pc with memory model data at pc; never two outstanding requests.

Source files
------------

// File: rtl/smol_pkg.sv
// smol_pkg: shared types and constants for the smol fetch stage.
package smol_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} fetch_state_t;
  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/smol_fetch_unit.sv
// smol_fetch_unit: PC register and single-outstanding instruction fetch with stale-response kill.
module smol_fetch_unit import smol_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] next_pc,
  input  logic            pc_load,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault
);
  fetch_state_t state, state_n, tgt;
  logic [XLEN-1:0] pc_eff, instr_n;
  logic kill, kill_n, valid, valid_n, run;
  // run holds off the first request until the edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc    <= RESET_PC;
      kill  <= 1'b0;
      valid <= 1'b0;
      instr <= INSTR_NOP;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_eff;
      kill  <= kill_n;
      valid <= valid_n;
      instr <= instr_n;
      run   <= 1'b1;
    end
  end
  always_comb begin
    pc_eff  = pc_load ? next_pc : pc;
    tgt     = misaligned(pc_eff) ? FAULT : REQ;
    state_n = state;
    kill_n  = kill;
    valid_n = valid;
    instr_n = instr;
    case (state)
      REQ:
        if (run && imem_gnt) begin
          state_n = WAIT;
          kill_n  = pc_load;
        end else if (pc_load) state_n = tgt;
      WAIT:
        if (imem_rvalid && (kill || pc_load)) begin
          kill_n  = 1'b0;
          state_n = tgt;
        end else if (imem_rvalid) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          state_n = HOLD;
        end else if (pc_load) kill_n = 1'b1;
      HOLD:
        if (pc_load) begin
          valid_n = 1'b0;
          state_n = tgt;
        end else if (instr_ready) valid_n = 1'b0;
      FAULT: state_n = pc_load ? tgt : FAULT;
      default: state_n = REQ;
    endcase
  end
  assign imem_req    = run && state == REQ;
  assign imem_addr   = pc;
  assign instr_valid = valid;
  assign fetch_fault = state == FAULT;
endmodule
